frac_blend: RTL

- Consumer end of the fractional-step scaler interface: takes the per-output-pixel advance/fraction/blank stream and fetches source pixels from a line buffer.
- Blends adjacent source pixels linearly per colour channel.
- Sits in the scandoubler output path, between the scaler step generator and video output.

---
 rtl/frac_blend.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/frac_blend.sv
`default_nettype none
// ============================================================================
// Module      : frac_blend
// Description : Fractional-step scaler consumer. Fetches source pixels from a
//               line buffer into a two-pixel window and linearly blends the
//               pair per colour channel using the top bits of the fraction.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_blend #(
  parameter int BITWIDTH   = 10,
  parameter int FRACWIDTH  = 16,
  parameter int COLOURBITS = 6,
  parameter int CHANNELS   = 3,
  parameter int WEIGHTBITS = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           line_start,
  input  logic                           step,
  input  logic                           adv,
  input  logic [FRACWIDTH-1:0]           fraction,
  input  logic                           blank,
  output logic [BITWIDTH-1:0]            rd_addr,
  input  logic [CHANNELS*COLOURBITS-1:0] rd_data,
  output logic [CHANNELS*COLOURBITS-1:0] pix_out,
  output logic                           pix_valid,
  output logic                           pix_blank
);

  localparam int C_PIXW = CHANNELS * COLOURBITS;
  localparam int C_MULW = COLOURBITS + WEIGHTBITS + 1;
  localparam logic [WEIGHTBITS:0]  C_ONE      = {1'b1, {WEIGHTBITS{1'b0}}};
  localparam logic [BITWIDTH-1:0]  C_ADDR_MAX = '1;
  localparam logic [BITWIDTH-1:0]  C_ADDR_ONE = BITWIDTH'(1);
  localparam logic [BITWIDTH-1:0]  C_ADDR_TWO = BITWIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME0 = 2'd1,
    S_PRIME1 = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t                  r_state;
  logic [BITWIDTH-1:0]     r_rd_addr;
  logic [C_PIXW-1:0]       r_p0;
  logic [C_PIXW-1:0]       r_p1;
  logic                    r_fill;     // first RUN cycle: p1 data is arriving
  logic                    r_step_d;
  logic                    r_s2_valid;
  logic                    r_s2_blank;
  logic [WEIGHTBITS-1:0]   r_s2_w;
  logic [C_PIXW-1:0]       r_pix_out;
  logic                    r_pix_valid;
  logic                    r_pix_blank;

  logic [WEIGHTBITS:0]     w_inv;
  logic [C_PIXW-1:0]       w_blend;

  assign rd_addr   = r_rd_addr;
  assign pix_out   = r_pix_out;
  assign pix_valid = r_pix_valid;
  assign pix_blank = r_pix_blank;

  // Weight applied to p0 is the complement of the latched weight.
  assign w_inv = C_ONE - {1'b0, r_s2_w};

  // Per-channel linear blend of the window, truncating shift.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [C_MULW-1:0] w_p0x;
    logic [C_MULW-1:0] w_p1x;
    logic [C_MULW-1:0] w_acc;
    assign w_p0x = {{(WEIGHTBITS+1){1'b0}}, r_p0[c*COLOURBITS +: COLOURBITS]};
    assign w_p1x = {{(WEIGHTBITS+1){1'b0}}, r_p1[c*COLOURBITS +: COLOURBITS]};
    assign w_acc = w_p0x * {{COLOURBITS{1'b0}}, w_inv}
                 + w_p1x * {{(COLOURBITS+1){1'b0}}, r_s2_w};
    assign w_blend[c*COLOURBITS +: COLOURBITS] = w_acc[WEIGHTBITS +: COLOURBITS];
  end

  // Line priming FSM, source window and stage-1 sample capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_fill     <= 1'b0;
      r_step_d   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_blank <= 1'b0;
      r_s2_w     <= '0;
    end else if (line_start) begin
      // Restart wins over everything; in-flight samples are dropped.
      r_state    <= S_PRIME0;
      r_rd_addr  <= '0;
      r_fill     <= 1'b0;
      r_step_d   <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_step_d   <= step;
      r_s2_valid <= 1'b0;
      case (r_state)
        S_PRIME0: begin
          r_state   <= S_PRIME1;
          r_rd_addr <= C_ADDR_ONE;
        end
        S_PRIME1: begin
          // rd_data now holds pixel 0; pixel 1 arrives one cycle later.
          r_state   <= S_RUN;
          r_p0      <= rd_data;
          r_rd_addr <= C_ADDR_TWO;
          r_fill    <= 1'b1;
        end
        S_RUN: begin
          if (r_fill) begin
            r_p1   <= rd_data;
            r_fill <= 1'b0;
          end
        end
        default: begin
        end
      endcase
      if (r_step_d) begin
        r_s2_valid <= 1'b1;
        r_s2_w     <= fraction[FRACWIDTH-1 -: WEIGHTBITS];
        if (r_state == S_RUN) begin
          r_s2_blank <= blank;
          // While p1 is still being filled the advance cannot be honoured.
          if (adv && !r_fill) begin
            r_p0 <= r_p1;
            r_p1 <= rd_data;
            if (r_rd_addr != C_ADDR_MAX) begin
              r_rd_addr <= r_rd_addr + C_ADDR_ONE;
            end
          end
        end else begin
          r_s2_blank <= 1'b1;
        end
      end
    end
  end

  // Stage 2: register blended pixel and its qualifiers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_out   <= '0;
      r_pix_valid <= 1'b0;
      r_pix_blank <= 1'b0;
    end else begin
      r_pix_valid <= r_s2_valid && !line_start;
      if (r_s2_valid && !line_start) begin
        r_pix_blank <= r_s2_blank;
        r_pix_out   <= r_s2_blank ? '0 : w_blend;
      end
    end
  end

endmodule
`default_nettype wire
